console_arbiter: RTL and testbench

- Merges NUM_CH independent uart_rx byte streams onto one shared UART transmitter.
- Each channel's bytes are buffered in a per-channel FIFO. The transmitter is granted a whole line at a time, so output lines from different consoles never interleave.
- Sits between the bank of uart_rx instances and a single uart_tx in the console multiplexer top level.

---
 rtl/console_mux_pkg.sv | 12 +
 rtl/console_fifo.sv | 52 +++++
 rtl/console_arbiter.sv | 136 +++++++++++++
 tb/tb_console_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_mux_pkg.sv
// rtl/console_mux_pkg.sv - shared types and helpers for the console multiplexer
package console_mux_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GUARD, WAIT} arb_state_t;

  localparam int DEFAULT_EOL_CHAR = 'h0A;

  function automatic int ch_idx_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// rtl/console_fifo.sv - per-channel first-word fall-through byte FIFO
module console_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/console_arbiter.sv
// rtl/console_arbiter.sv - line-granular round-robin merge of uart_rx streams onto one uart_tx
module console_arbiter
  import console_mux_pkg::*;
#(
  parameter  int                        NUM_CH         = 4,
  parameter  int                        DATA_BIT_COUNT = 8,
  parameter  int                        FIFO_DEPTH     = 16,
  parameter  logic [DATA_BIT_COUNT-1:0] EOL_CHAR       = DATA_BIT_COUNT'(DEFAULT_EOL_CHAR),
  localparam int                        CW             = ch_idx_width(NUM_CH),
  localparam int                        AW             = $clog2(FIFO_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                rx_ready,
  input  logic [NUM_CH*DATA_BIT_COUNT-1:0] rx_data,
  input  logic                             tx_busy,
  output logic                             tx_start,
  output logic [DATA_BIT_COUNT-1:0]        tx_data,
  output logic [CW-1:0]                    grant,
  output logic                             grant_valid,
  output logic [NUM_CH-1:0]                overflow
);

  arb_state_t                                   state, state_n;
  logic [NUM_CH-1:0]                            prev_ready;
  logic [NUM_CH-1:0]                            push, pop, full, empty, eligible;
  logic [NUM_CH-1:0][DATA_BIT_COUNT-1:0]        dout;
  logic [NUM_CH-1:0][AW:0]                      count;
  logic [CW-1:0]                                rr_ptr, pick, cand;
  logic                                         pick_valid, send_go, release_go, last_eol;
  int                                           idx;

  // uart_rx ready is a level, so a new byte shows up as its rising edge
  assign push = rx_ready & ~prev_ready;
  assign pop  = send_go ? (NUM_CH'(1) << grant) : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [AW:0] line_cnt;
    logic        inc, dec;

    console_fifo #(.WIDTH(DATA_BIT_COUNT), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (rx_data[i*DATA_BIT_COUNT +: DATA_BIT_COUNT]),
      .dout  (dout[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (count[i])
    );

    assign inc = push[i] && (!full[i] || pop[i]) &&
                 (rx_data[i*DATA_BIT_COUNT +: DATA_BIT_COUNT] == EOL_CHAR);
    assign dec = pop[i] && !empty[i] && (dout[i] == EOL_CHAR);

    always_ff @(posedge clk) begin
      if (rst)              line_cnt <= '0;
      else if (inc && !dec) line_cnt <= line_cnt + 1'b1;
      else if (dec && !inc) line_cnt <= line_cnt - 1'b1;
    end

    // A full FIFO with no complete line is flushed anyway so it can drain
    assign eligible[i] = (line_cnt != '0) || full[i];
  end

  always_comb begin
    pick       = rr_ptr;
    pick_valid = 1'b0;
    idx        = 0;
    cand       = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx  = (int'(rr_ptr) + k) % NUM_CH;
      cand = CW'(idx);
      if (eligible[cand]) begin
        pick       = cand;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_n    = state;
    send_go    = 1'b0;
    release_go = 1'b0;
    case (state)
      IDLE:  if (pick_valid) state_n = SEND;
      SEND:  if (!tx_busy) begin
               send_go = 1'b1;
               state_n = GUARD;
             end
      GUARD: state_n = WAIT;
      WAIT:  if (!tx_busy) begin
               if (last_eol || count[grant] == '0) begin
                 release_go = 1'b1;
                 state_n    = IDLE;
               end else begin
                 state_n = SEND;
               end
             end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      prev_ready  <= '1;
      rr_ptr      <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      last_eol    <= 1'b0;
      overflow    <= '0;
    end else begin
      state      <= state_n;
      prev_ready <= rx_ready;
      tx_start   <= send_go;
      overflow   <= overflow | (push & full & ~pop);
      if (state == IDLE && pick_valid) begin
        grant       <= pick;
        grant_valid <= 1'b1;
      end
      if (send_go) begin
        tx_data  <= dout[grant];
        last_eol <= (dout[grant] == EOL_CHAR);
      end
      if (release_go) begin
        grant_valid <= 1'b0;
        rr_ptr      <= (grant == CW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_console_arbiter.sv
// tb/tb_console_arbiter.sv - self-checking bench for console_arbiter
module tb_console_arbiter;

  localparam int         NCH   = 4;
  localparam int         W     = 8;
  localparam int         DEPTH = 16;
  localparam logic [7:0] EOL   = 8'h0A;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NCH-1:0] rx_ready = '0;
  logic [NCH*W-1:0] rx_data = '0;
  logic           tx_busy = 1'b0;
  logic           tx_start;
  logic [W-1:0]   tx_data;
  logic [1:0]     grant;
  logic           grant_valid;
  logic [NCH-1:0] overflow;

  always #5 clk = ~clk;

  console_arbiter #(.NUM_CH(NCH), .DATA_BIT_COUNT(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .grant       (grant),
    .grant_valid (grant_valid),
    .overflow    (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-channel byte queues holding what the DUT must still send
  logic [7:0]     mbuf [NCH][256];
  int             mhead [NCH];
  int             mtail [NCH];
  logic [NCH-1:0] m_ovf = '0;
  logic [7:0]     last_sent [NCH];
  logic [7:0]     log_data [$];
  int             log_ch [$];
  int             glog [$];
  int             busy_len = 3;
  bit             force_busy = 1'b0;
  int             busy_cnt = 0;
  logic [7:0]     last_data = '0;
  logic           prev_gv = 1'b0;
  logic [1:0]     prev_grant = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_pending();
    for (int c = 0; c < NCH; c++) if (mhead[c] != mtail[c]) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    for (int c = 0; c < NCH; c++) begin
      mhead[c] = 0;
      mtail[c] = 0;
      last_sent[c] = '0;
    end
  end

  // Transmitter model: busy rises the cycle after start and holds busy_len cycles
  initial forever begin
    @(negedge clk);
    if (tx_start === 1'b1) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = force_busy || (busy_cnt > 0);
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      check("rst_tx_start", tx_start, 0);
      check("rst_grant_valid", grant_valid, 0);
      check("rst_grant", grant, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_overflow", overflow, 0);
      for (int c = 0; c < NCH; c++) mhead[c] = mtail[c];
      m_ovf     = '0;
      last_data = '0;
      prev_gv   = 1'b0;
    end else begin
      if (tx_start) begin
        check("strobe_while_busy", tx_busy, 0);
        check("strobe_granted", grant_valid, 1);
        check("strobe_has_data", mhead[grant] != mtail[grant], 1);
        if (mhead[grant] != mtail[grant]) begin
          check("tx_data", tx_data, mbuf[grant][mhead[grant] % 256]);
          mhead[grant]++;
        end
        last_data        = tx_data;
        last_sent[grant] = tx_data;
        log_data.push_back(tx_data);
        log_ch.push_back(int'(grant));
      end else begin
        check("tx_data_hold", tx_data, last_data);
      end
      check("overflow", overflow, m_ovf);
      if (prev_gv && grant_valid) check("grant_stable", grant, prev_grant);
      if (!prev_gv && grant_valid) glog.push_back(int'(grant));
      if (prev_gv && !grant_valid)
        check("release_rule",
              (last_sent[prev_grant] == EOL) || (mhead[prev_grant] == mtail[prev_grant]), 1);
      prev_gv    = grant_valid;
      prev_grant = grant;
    end
  end

  task automatic push_mask(input logic [NCH-1:0] mask, input logic [7:0] b);
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (mask[c]) begin
        rx_data[c*W +: W] = b;
        rx_ready[c] = 1'b1;
        if (mtail[c] - mhead[c] >= DEPTH) m_ovf[c] = 1'b1;
        else begin
          mbuf[c][mtail[c] % 256] = b;
          mtail[c]++;
        end
      end
    end
    @(negedge clk);
    rx_ready = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    log_data.delete();
    log_ch.delete();
    glog.delete();
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while ((model_pending() || grant_valid || tx_busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, n < limit, 1);
  endtask

  initial begin
    logic [7:0] exp2 [6];
    int         n;
    exp2 = '{8'h41, 8'h42, 8'h0A, 8'h78, 8'h79, 8'h0A};

    // Single line with cycle-exact grant and first-strobe latency
    do_reset();
    push_mask(4'b0010, 8'h68);
    push_mask(4'b0010, 8'h69);
    push_mask(4'b0010, 8'h0A);
    check("line_no_grant_yet", grant_valid, 0);
    @(negedge clk);
    check("line_grant_valid", grant_valid, 1);
    check("line_grant", grant, 1);
    check("line_no_early_start", tx_start, 0);
    @(negedge clk);
    check("line_first_start", tx_start, 1);
    check("line_first_byte", tx_data, 8'h68);
    wait_drain("line_drain", 200);
    check("line_count", log_data.size(), 3);
    if (log_data.size() == 3) begin
      check("line_b1", log_data[1], 8'h69);
      check("line_b2", log_data[2], 8'h0A);
    end
    check("line_overflow", overflow, 0);

    // Two lines built from alternating bytes leave the TX unmixed
    do_reset();
    push_mask(4'b0001, 8'h41);
    push_mask(4'b0100, 8'h78);
    push_mask(4'b0001, 8'h42);
    push_mask(4'b0100, 8'h79);
    push_mask(4'b0001, 8'h0A);
    push_mask(4'b0100, 8'h0A);
    wait_drain("mix_drain", 300);
    check("mix_count", log_data.size(), 6);
    if (log_data.size() == 6)
      for (int i = 0; i < 6; i++) begin
        check("mix_byte", log_data[i], exp2[i]);
        check("mix_ch", log_ch[i], (i < 3) ? 0 : 2);
      end

    // Round robin from pointer 0, then pointer wraps back to 0 after ch3
    do_reset();
    push_mask(4'b1011, 8'h61);
    push_mask(4'b1011, 8'h0A);
    wait_drain("rr_drain", 400);
    push_mask(4'b1001, 8'h7A);
    push_mask(4'b1001, 8'h0A);
    wait_drain("rr_drain2", 400);
    check("rr_grants", glog.size(), 5);
    if (glog.size() == 5) begin
      check("rr_g0", glog[0], 0);
      check("rr_g1", glog[1], 1);
      check("rr_g2", glog[2], 3);
      check("rr_g3", glog[3], 0);
      check("rr_g4", glog[4], 3);
    end

    // Overflow and forced flush of a full FIFO with no line end
    do_reset();
    force_busy = 1'b1;
    for (int k = 0; k < 17; k++) push_mask(4'b0100, 8'h30 + 8'(k));
    @(negedge clk);
    check("ovf_flag", overflow, 4'b0100);
    check("ovf_grant", grant, 2);
    check("ovf_no_start", log_data.size(), 0);
    force_busy = 1'b0;
    wait_drain("ovf_drain", 600);
    check("ovf_sent", log_data.size(), 16);
    if (log_data.size() == 16) begin
      check("ovf_first", log_data[0], 8'h30);
      check("ovf_last", log_data[15], 8'h3F);
    end
    check("ovf_single_grant", glog.size(), 1);
    check("ovf_sticky", overflow, 4'b0100);

    // Long busy: one strobe per byte, none while busy
    do_reset();
    busy_len = 100;
    push_mask(4'b0001, 8'h61);
    push_mask(4'b0001, 8'h62);
    push_mask(4'b0001, 8'h0A);
    wait_drain("busy_drain", 1000);
    check("busy_strobes", log_data.size(), 3);

    // Reset while waiting on the TX with 5 bytes still queued
    do_reset();
    busy_len = 20;
    for (int k = 0; k < 5; k++) push_mask(4'b0010, 8'h31 + 8'(k));
    push_mask(4'b0010, 8'h0A);
    n = 0;
    while (tx_start !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_first_start", n < 50, 1);
    repeat (3) @(negedge clk);
    check("mid_waiting", grant_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_gv_cleared", grant_valid, 0);
    check("mid_no_start", tx_start, 0);
    @(negedge clk);
    check("mid_no_start_after", tx_start, 0);
    repeat (40) @(negedge clk);
    check("mid_no_more_bytes", log_data.size(), 1);
    busy_len = 3;
    push_mask(4'b0001, 8'h6F);
    push_mask(4'b0001, 8'h6B);
    push_mask(4'b0001, 8'h0A);
    wait_drain("mid_drain", 300);
    check("mid_after_count", log_data.size(), 4);
    if (log_data.size() == 4) begin
      check("mid_after_b0", log_data[1], 8'h6F);
      check("mid_after_b2", log_data[3], 8'h0A);
      check("mid_after_ch", log_ch[3], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
